// File: rtl/jpeg_enc_pkg.sv
// Shared types and constants for the JPEG encoder front end.
`default_nettype none

package jpeg_enc_pkg;

  localparam int PIX_PER_BLOCK = 64;
  localparam int PIX_IDX_W     = 6;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } rgb_t;

  typedef struct packed {
    logic [7:0] cr;
    logic [7:0] cb;
    logic [7:0] y;
  } ycc_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/rgb2ycrcb_sched_if.sv
// Pixel-side streams of the colour-conversion scheduler: RGB in, tagged YCbCr out.
`default_nettype none

interface rgb2ycrcb_sched_if;
  import jpeg_enc_pkg::*;

  logic in_valid;
  logic in_ready;
  rgb_t in_rgb;
  logic out_valid;
  logic out_ready;
  ycc_t out_ycc;
  logic out_sob;
  logic out_eob;
  logic out_eof;

  // master = pixel source / block-stage sink, slave = scheduler
  modport master (
    output in_valid, in_rgb, out_ready,
    input  in_ready, out_valid, out_ycc, out_sob, out_eob, out_eof
  );

  modport slave (
    input  in_valid, in_rgb, out_ready,
    output in_ready, out_valid, out_ycc, out_sob, out_eob, out_eof
  );

endinterface

`default_nettype wire

// File: rtl/rgb2ycrcb_sched_ycc_fifo.sv
// Synchronous first-word-fall-through FIFO; push and pop may coincide at any level.
`default_nettype none

module ycc_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 24,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_data,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_data,
  output logic      [CW-1:0]    o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= next_ptr(r_wr);
      end
      if (w_do_pop) r_rd <= next_ptr(r_rd);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/rgb2ycrcb_sched.sv
// Credit-based issue controller around the fixed-latency RGB->YCbCr converter,
// buffering results and tagging block/frame boundaries on the output stream.
`default_nettype none

module rgb2ycrcb_sched
  import jpeg_enc_pkg::*;
#(
  parameter int PIPE_LAT   = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int NB_W       = 16
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            start,
  input  wire logic [NB_W-1:0] num_blocks,
  rgb2ycrcb_sched_if.slave     pix,
  output logic                 dp_enable,
  output rgb_t                 dp_data_in,
  input  wire ycc_t            dp_data_out,
  input  wire logic            dp_enable_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int TOT_W = NB_W + PIX_IDX_W;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int IF_W  = $clog2(FIFO_DEPTH + PIPE_LAT + 1);
  localparam int SUM_W = ((CW > IF_W) ? CW : IF_W) + 1;

  sched_state_t         r_state;
  logic [NB_W-1:0]      r_nb;
  logic [TOT_W-1:0]     r_total;
  logic [TOT_W-1:0]     r_issued;
  logic [IF_W-1:0]      r_inflight;
  logic [PIX_IDX_W-1:0] r_pc;
  logic [NB_W-1:0]      r_blk;
  logic                 r_err;
  logic                 r_dp_en;
  rgb_t                 r_dp_data;

  logic [CW-1:0]        w_fifo_count;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [23:0]          w_head;
  logic [SUM_W-1:0]     w_occupancy;
  logic                 w_in_ready;
  logic                 w_hs;
  logic                 w_res_ok;
  logic                 w_pop;
  logic                 w_eob;

  // Every issued pixel owns a FIFO slot until popped, so the converter never overruns.
  assign w_occupancy = SUM_W'(w_fifo_count) + SUM_W'(r_inflight);
  assign w_in_ready  = (r_state == RUN) && (w_occupancy < SUM_W'(FIFO_DEPTH)) &&
                       (r_issued < r_total) && !w_fifo_full;
  assign w_hs        = pix.in_valid && w_in_ready;
  assign w_res_ok    = dp_enable_out && (r_inflight != '0);
  assign w_pop       = !w_fifo_empty && pix.out_ready;
  assign w_eob       = !w_fifo_empty && (r_pc == PIX_IDX_W'(PIX_PER_BLOCK - 1));

  ycc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (24)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_res_ok),
    .i_data  (dp_data_out),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_nb       <= '0;
      r_total    <= '0;
      r_issued   <= '0;
      r_inflight <= '0;
      r_pc       <= '0;
      r_blk      <= '0;
      r_err      <= 1'b0;
      r_dp_en    <= 1'b0;
      r_dp_data  <= '0;
    end else begin
      r_dp_en <= w_hs;
      if (w_hs) begin
        r_dp_data <= pix.in_rgb;
        r_issued  <= r_issued + 1'b1;
      end
      case ({w_hs, w_res_ok})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
      if (w_pop) begin
        r_pc <= r_pc + 1'b1;
        if (r_pc == PIX_IDX_W'(PIX_PER_BLOCK - 1)) r_blk <= r_blk + 1'b1;
      end
      // A result with nothing outstanding is orphaned (e.g. reset mid-frame).
      if (dp_enable_out && (r_inflight == '0)) r_err <= 1'b1;
      else if (start && (r_state == IDLE))    r_err <= 1'b0;

      case (r_state)
        IDLE: if (start) begin
          r_nb     <= num_blocks;
          r_total  <= {num_blocks, {PIX_IDX_W{1'b0}}};
          r_issued <= '0;
          r_pc     <= '0;
          r_blk    <= '0;
          r_state  <= (num_blocks != '0) ? RUN : DONE;
        end
        RUN:     if (r_issued == r_total) r_state <= DRAIN;
        DRAIN:   if ((r_inflight == '0) && w_fifo_empty) r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pix.in_ready  = w_in_ready;
  assign pix.out_valid = !w_fifo_empty;
  assign pix.out_ycc   = ycc_t'(w_head);
  assign pix.out_sob   = !w_fifo_empty && (r_pc == '0);
  assign pix.out_eob   = w_eob;
  assign pix.out_eof   = w_eob && (r_blk == r_nb - 1'b1);

  assign dp_enable  = r_dp_en;
  assign dp_data_in = r_dp_data;
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);
  assign err        = r_err;

endmodule

`default_nettype wire
